// File: rtl/exc_gen_if.sv
// exc_gen_if: pipeline-side and CP0-side signals of the exception generator
interface exc_gen_if;
    logic        stall;
    logic        flush_i;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        in_delay_i;
    logic        adel_i;
    logic        ri_i;
    logic        ov_i;
    logic        sys_i;
    logic        bp_i;
    logic        ades_i;
    logic        eret_i;
    logic [5:0]  hw_int_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [4:0]  exccode_o;
    logic [31:0] pc_o;
    logic        in_delay_o;
    logic [5:0]  int_o;

    modport master (
        output stall, flush_i, valid_i, pc_i, in_delay_i, adel_i, ri_i, ov_i,
               sys_i, bp_i, ades_i, eret_i, hw_int_i, status_i, cause_i,
        input  exccode_o, pc_o, in_delay_o, int_o
    );

    modport slave (
        input  stall, flush_i, valid_i, pc_i, in_delay_i, adel_i, ri_i, ov_i,
               sys_i, bp_i, ades_i, eret_i, hw_int_i, status_i, cause_i,
        output exccode_o, pc_o, in_delay_o, int_o
    );
endinterface

// File: rtl/exc_gen.sv
// exc_gen: MEM-stage exception prioritiser with one-shot reporting to CP0
module exc_gen (
    input logic     clk,
    input logic     rst_n,
    exc_gen_if.slave bus
);
    typedef enum logic {IDLE, BLOCK} state_t;

    localparam logic [4:0] NONE = 5'h10;

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic        dly_q, dly_d;
    logic [6:0]  flags_q, flags_d;
    logic [5:0]  sync1_q, sync2_q;
    logic        int_pend;
    logic [4:0]  code;
    logic        unused;

    assign unused   = ^{bus.status_i[31:16], bus.status_i[7:2], bus.cause_i[31:16], bus.cause_i[7:0]};
    assign int_pend = bus.status_i[0] & ~bus.status_i[1] & |(bus.cause_i[15:8] & bus.status_i[15:8]);

    // Highest-priority cause of the held instruction; silent when empty or in the dead cycle
    always_comb begin
        code = NONE;
        if (state_q == IDLE && valid_q)
            code = int_pend   ? 5'h00 :
                   flags_q[0] ? 5'h04 :
                   flags_q[1] ? 5'h0a :
                   flags_q[2] ? 5'h0c :
                   flags_q[3] ? 5'h08 :
                   flags_q[4] ? 5'h09 :
                   flags_q[5] ? 5'h05 :
                   flags_q[6] ? 5'h11 : NONE;
        state_d = (state_q == IDLE && code != NONE) ? BLOCK : IDLE;
    end

    // Stage load on no-stall; a flush or a just-reported event empties the stage
    always_comb begin
        valid_d = bus.stall ? valid_q : bus.valid_i;
        pc_d    = bus.stall ? pc_q    : bus.pc_i;
        dly_d   = bus.stall ? dly_q   : bus.in_delay_i;
        flags_d = bus.stall ? flags_q :
                  {bus.eret_i, bus.ades_i, bus.bp_i, bus.sys_i, bus.ov_i, bus.ri_i, bus.adel_i};
        if (bus.flush_i || code != NONE)
            valid_d = 1'b0;
    end

    // Stage register, FSM and two-flop interrupt synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            pc_q    <= '0;
            dly_q   <= 1'b0;
            flags_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            dly_q   <= dly_d;
            flags_q <= flags_d;
            sync1_q <= bus.hw_int_i;
            sync2_q <= sync1_q;
        end
    end

    assign bus.exccode_o  = code;
    assign bus.pc_o       = pc_q;
    assign bus.in_delay_o = dly_q;
    assign bus.int_o      = sync2_q;
endmodule

// File: tb/tb_exc_gen.sv
// tb_exc_gen: directed and randomized checks of exc_gen against a cause-table model
module tb_exc_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exc_gen_if bus();

    exc_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: the instruction held in MEM, whether the last cycle reported, interrupt history
    logic        m_v, m_d, m_dead;
    logic [31:0] m_pc;
    logic [6:0]  m_f;
    logic [5:0]  m_h0, m_h1;
    logic [4:0]  prio [7] = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h05, 5'h11};

    function automatic logic [4:0] ref_code();
        logic pend;
        pend = bus.status_i[0] && !bus.status_i[1] && ((bus.cause_i[15:8] & bus.status_i[15:8]) != 8'h0);
        if (!m_v || m_dead) return 5'h10;
        if (pend) return 5'h00;
        for (int i = 0; i < 7; i++)
            if (m_f[i]) return prio[i];
        return 5'h10;
    endfunction

    task automatic model_reset();
        m_v = 0; m_d = 0; m_dead = 0; m_pc = 0; m_f = 0; m_h0 = 0; m_h1 = 0;
    endtask

    task automatic model_step();
        logic [4:0] c;
        c = ref_code();
        m_dead = (c != 5'h10);
        if (!bus.stall) begin
            m_v  = bus.valid_i;
            m_pc = bus.pc_i;
            m_d  = bus.in_delay_i;
            m_f  = {bus.eret_i, bus.ades_i, bus.bp_i, bus.sys_i, bus.ov_i, bus.ri_i, bus.adel_i};
        end
        if (bus.flush_i || m_dead) m_v = 0;
        m_h1 = m_h0;
        m_h0 = bus.hw_int_i;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        chk("exccode", 32'(bus.exccode_o), 32'(ref_code()));
        chk("pc_o", bus.pc_o, m_pc);
        chk("in_delay_o", 32'(bus.in_delay_o), 32'(m_d));
        chk("int_o", 32'(bus.int_o), 32'(m_h1));
    endtask

    task automatic clk_edge();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
    endtask

    task automatic set_ins(input logic v, input logic [31:0] pc, input logic dly,
                           input logic [6:0] f, input logic st, input logic fl);
        bus.valid_i = v; bus.pc_i = pc; bus.in_delay_i = dly; bus.stall = st; bus.flush_i = fl;
        {bus.eret_i, bus.ades_i, bus.bp_i, bus.sys_i, bus.ov_i, bus.ri_i, bus.adel_i} = f;
    endtask

    task automatic reset_outs(input string tag);
        chk({tag, "_code"}, 32'(bus.exccode_o), 32'h10);
        chk({tag, "_pc"}, bus.pc_o, 32'h0);
        chk({tag, "_dly"}, 32'(bus.in_delay_o), 32'h0);
        chk({tag, "_int"}, 32'(bus.int_o), 32'h0);
    endtask

    initial begin
        int n9;
        model_reset();
        set_ins(0, 0, 0, 0, 0, 0);
        bus.hw_int_i = 0; bus.status_i = 0; bus.cause_i = 0;
        #1 reset_outs("reset");
        clk_edge();
        clk_edge();
        rst_n = 1'b1;
        sample(); clk_edge();

        // Syscall reported once with its PC
        set_ins(1, 32'h80000010, 0, 7'b0001000, 0, 0);
        sample(); clk_edge();
        set_ins(0, 0, 0, 0, 0, 0);
        sample();
        chk("sys_code", 32'(bus.exccode_o), 32'h08);
        chk("sys_pc", bus.pc_o, 32'h80000010);
        clk_edge();
        sample();
        chk("sys_after", 32'(bus.exccode_o), 32'h10);
        clk_edge();

        // RI beats Ov in a delay slot
        set_ins(1, 32'h80000020, 1, 7'b0000110, 0, 0);
        sample(); clk_edge();
        set_ins(0, 0, 0, 0, 0, 0);
        sample();
        chk("ri_code", 32'(bus.exccode_o), 32'h0a);
        chk("ri_dly", 32'(bus.in_delay_o), 32'h1);
        clk_edge();
        sample(); clk_edge();

        // Eret combined with AdES reports AdES; flush beats an entering instruction
        set_ins(1, 32'h80000030, 0, 7'b1100000, 0, 0);
        sample(); clk_edge();
        set_ins(1, 32'h80000034, 0, 7'b0001000, 0, 1);
        sample();
        chk("ades_code", 32'(bus.exccode_o), 32'h05);
        clk_edge();
        set_ins(0, 0, 0, 0, 0, 0);
        sample(); clk_edge();
        sample();
        chk("flush_code", 32'(bus.exccode_o), 32'h10);
        clk_edge();

        // Interrupt: synchroniser latency, wait for a valid stage, then report
        bus.status_i = 32'h0000_0401;
        bus.hw_int_i = 6'h01;
        sample(); clk_edge();
        sample();
        chk("int_lat1", 32'(bus.int_o[0]), 32'h0);
        clk_edge();
        sample();
        chk("int_lat2", 32'(bus.int_o[0]), 32'h1);
        bus.cause_i = 32'h0000_0400;
        clk_edge();
        sample();
        chk("int_wait", 32'(bus.exccode_o), 32'h10);
        set_ins(1, 32'h80000100, 0, 0, 0, 0);
        clk_edge();
        set_ins(0, 0, 0, 0, 0, 0);
        sample();
        chk("int_code", 32'(bus.exccode_o), 32'h00);
        chk("int_pc", bus.pc_o, 32'h80000100);
        clk_edge();
        sample(); clk_edge();

        // EXL masks the same interrupt
        bus.status_i = 32'h0000_0403;
        set_ins(1, 32'h80000200, 0, 0, 0, 0);
        sample(); clk_edge();
        set_ins(0, 0, 0, 0, 0, 0);
        sample();
        chk("exl_mask", 32'(bus.exccode_o), 32'h10);
        clk_edge();
        bus.status_i = 0; bus.cause_i = 0; bus.hw_int_i = 0;

        // Breakpoint held under stall reports exactly once
        set_ins(1, 32'h80000300, 0, 7'b0010000, 0, 0);
        sample(); clk_edge();
        set_ins(1, 32'h80000304, 0, 7'b0001000, 1, 0);
        n9 = 0;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (bus.exccode_o == 5'h09) n9++;
            clk_edge();
        end
        chk("bp_once", 32'(n9), 32'd1);
        set_ins(0, 0, 0, 0, 0, 0);
        sample(); clk_edge();

        // Reset mid-exception drops it; eret after release reported once
        set_ins(1, 32'h80000400, 1, 7'b0001000, 0, 0);
        bus.hw_int_i = 6'h3f;
        sample(); clk_edge();
        set_ins(0, 0, 0, 0, 0, 0);
        sample();
        chk("pre_rst", 32'(bus.exccode_o), 32'h08);
        #2 rst_n = 1'b0;
        #1 reset_outs("mid_rst");
        model_reset();
        clk_edge();
        rst_n = 1'b1;
        bus.hw_int_i = 0;
        sample();
        chk("post_rst", 32'(bus.exccode_o), 32'h10);
        clk_edge();
        set_ins(1, 32'h80000500, 0, 7'b1000000, 0, 0);
        sample(); clk_edge();
        set_ins(0, 0, 0, 0, 0, 0);
        sample();
        chk("eret_code", 32'(bus.exccode_o), 32'h11);
        clk_edge();
        sample();
        chk("eret_after", 32'(bus.exccode_o), 32'h10);
        clk_edge();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [6:0] f;
            for (int b = 0; b < 7; b++) f[b] = ($urandom_range(9) == 0);
            set_ins($urandom_range(3) != 0, $urandom, 1'($urandom), f,
                    $urandom_range(3) == 0, $urandom_range(15) == 0);
            bus.hw_int_i = 6'($urandom);
            bus.status_i = {16'h0, 8'($urandom), 6'h0, $urandom_range(3) == 0, 1'($urandom)};
            bus.cause_i  = {16'h0, ($urandom_range(3) == 0) ? 8'($urandom) : 8'h0, 8'h0};
            sample(); clk_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exc_gen.md
EXC_GEN -- requirements
Module: exc_gen

Interface
REQ-001 SHALL have ports as listed below; one clock; reset asynchronous, active-low:
  clk  in  1  system clock, all state on rising edge
  rst_n  in  1  async active-low reset
  stall  in  1  MEM stage hold; stage register keeps contents
  flush_i  in  1  pipeline flush from CP0; invalidates stage register
  valid_i  in  1  instruction entering stage is real (not bubble)
  pc_i  in  32  PC of entering instruction
  in_delay_i  in  1  entering instruction sits in branch delay slot
  adel_i, ri_i, ov_i, sys_i, bp_i, ades_i, eret_i  in  1 each  per-cause flags of entering instruction
  hw_int_i  in  6  raw asynchronous external interrupt lines
  status_i  in  32  CP0 Status (IE=bit0, EXL=bit1, IM=bits15:8)
  cause_i  in  32  CP0 Cause (IP=bits15:8)
  exccode_o  out  5  event code to CP0: 5'h10 none, 5'h11 eret, else MIPS ExcCode
  pc_o  out  32  PC of reported instruction
  in_delay_o  out  1  delay-slot flag of reported instruction
  int_o  out  6  synchronised hw_int_i, feeds CP0 Cause IP[7:2]

Function
REQ-002 SHALL hold one stage register {valid, pc, in_delay, 7 flags}; loads inputs on rising edge when stall=0.
REQ-003 SHALL clear stage valid on edge when flush_i=1, overriding load and stall.
REQ-004 SHALL clear stage valid on edge following any cycle with exccode_o != 5'h10, regardless of stall.
REQ-005 SHALL drive pc_o/in_delay_o directly from stage register (latency 1 cycle from input sample).
REQ-006 SHALL synchronise hw_int_i through two flops; int_o = second flop; latency 2 rising edges.
REQ-007 SHALL compute int_pend = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
REQ-008 SHALL compute exccode_o combinationally from stage register, int_pend, FSM state; 5'h10 when stage valid=0.
REQ-009 SHALL apply priority, highest first: interrupt 5'h00, AdEL 5'h04, RI 5'h0a, Ov 5'h0c, Sys 5'h08, Bp 5'h09, AdES 5'h05, eret 5'h11.
REQ-010 SHALL report interrupt only with stage valid=1 (pc_o meaningful); pending interrupt with invalid stage waits, not dropped.
REQ-011 SHALL implement FSM IDLE/BLOCK; IDLE->BLOCK on edge after exccode_o != 5'h10; BLOCK->IDLE next edge unconditionally.
REQ-012 SHALL force exccode_o=5'h10 in BLOCK (one dead cycle while CP0 Status/EPC settle).
REQ-013 SHALL treat multiple flags in one instruction as single event: only highest-priority code reported, once.
REQ-014 SHALL let eret_i with any other flag report the other code, not 5'h11.
REQ-015 SHALL, with stall=1 and pending exception, report exactly once, then output 5'h10 until a new instruction loads.
REQ-016 SHALL give flush_i and valid_i=1 in same cycle precedence to flush (valid cleared).

Reset
REQ-017 SHALL on rst_n=0 asynchronously clear stage register, both synchroniser stages, FSM=IDLE.
REQ-018 SHALL hold outputs during reset: exccode_o=5'h10, pc_o=0, in_delay_o=0, int_o=0.
REQ-019 SHALL discard an in-flight exception when reset asserts mid-operation; no report after release until new instruction loads.

Verification
REQ-020 SHALL cover: valid_i=1, pc_i=32'h80000010, sys_i=1 -> next cycle exccode_o=5'h08, pc_o=32'h80000010; following cycle 5'h10.
REQ-021 SHALL cover: ov_i=1, ri_i=1, in_delay_i=1 -> exccode_o=5'h0a once, in_delay_o=1.
REQ-022 SHALL cover: status_i=32'h0000_0401, hw_int_i[0] rising, cause_i[10] returned set -> interrupt code 5'h00 on next valid instruction; int_o[0] high 2 edges after hw_int_i.
REQ-023 SHALL cover: same interrupt with status_i[1]=1 -> exccode_o stays 5'h10.
REQ-024 SHALL cover: stall=1 held 4 cycles with bp_i=1 -> exccode_o=5'h09 exactly one cycle.
REQ-025 SHALL cover: rst_n low mid-exception -> all outputs reset values immediately; eret_i after release -> 5'h11 one cycle.
